// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Data-memory responder for the dmem bus. It sits behind the MemAccess stage.
// Each request strobe produces one read or write access. The access takes
// place after WAIT_CYCLES wait states and is acknowledged by a one-cycle
// complete_data pulse. Read data is valid on Data_dout while complete_data is
// high, and it stays there until the next read completes.
//
// Parameters
//   DEPTH        number of 16-bit words (power of two, 2..65536)
//   WAIT_CYCLES  wait states inserted per access (0..15)
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous, active-low reset
//   Data_req       in   request strobe, sampled only in IDLE
//   Data_rd        in   1 = read, 0 = write
//   Data_addr[15:0] in  word address
//   Data_din[15:0]  in  write data
//   Data_dout[15:0] out registered read data
//   complete_data  out  one-cycle completion pulse
//   Data_err       out  out-of-range flag (only with DMEM_OOR_ERR_EN)
//
// Build option
//   DMEM_OOR_ERR_EN  When this is defined, an address >= DEPTH is flagged
//                    instead of wrapping. Writes to a flagged address are
//                    dropped, and reads from one return 16'hDEAD.
//                    When it is undefined, addresses wrap modulo DEPTH.
//
// Memory contents are neither initialised nor cleared by reset.
// ---------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data
`ifdef DMEM_OOR_ERR_EN
  ,
  output logic        Data_err
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WC      = 4'(WAIT_CYCLES);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmpl_q, cmpl_d;
  logic        err_q, err_d;
  logic [15:0] dout_q, dout_d;

  // Request fields captured in IDLE and held for the rest of the transaction.
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;

  logic [15:0] mem [DEPTH];

  logic          access;
  logic          acc_rd;
  logic [15:0]   acc_addr;
  logic [15:0]   acc_din;
  logic [AW-1:0] idx;
  logic          oor;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  // When WAIT_CYCLES is 0, the access happens on the same edge that samples
  // the request. The live bus is used in IDLE for that reason. Every other
  // access uses the latched copy.
  always_comb begin
    acc_rd   = rd_q;
    acc_addr = addr_q;
    acc_din  = din_q;
    if (state_q == S_IDLE) begin
      acc_rd   = Data_rd;
      acc_addr = Data_addr;
      acc_din  = Data_din;
    end
  end

  assign idx       = acc_addr[AW-1:0];
  assign mem_rdata = mem[idx];

  always_comb begin
`ifdef DMEM_OOR_ERR_EN
    oor = ({1'b0, acc_addr} >= DEPTH_L);
`else
    oor = 1'b0;
`endif
  end

  // The access edge is the edge that moves the FSM into DONE.
  always_comb begin
    access = 1'b0;
    if ((state_q == S_IDLE) && Data_req && (WC == 4'd0)) begin
      access = 1'b1;
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd0)) begin
      access = 1'b1;
    end
  end

  // The write enable is gated by reset. A write that is aborted by reset
  // therefore never lands, even though the array itself has no reset.
  assign mem_we = access && !acc_rd && !oor && reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE: begin
        if (Data_req) begin
          rd_d   = Data_rd;
          addr_d = Data_addr;
          din_d  = Data_din;
          if (WC == 4'd0) begin
            state_d = S_DONE;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WC - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The outputs are registered. They are computed together with the access
  // so that they line up with the DONE cycle.
  always_comb begin
    cmpl_d = 1'b0;
    err_d  = 1'b0;
    dout_d = dout_q;
    if (access) begin
      cmpl_d = 1'b1;
      err_d  = oor;
      if (acc_rd) begin
        dout_d = oor ? 16'hDEAD : mem_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cmpl_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmpl_q  <= cmpl_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clock) begin
    rd_q   <= rd_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx] <= acc_din;
    end
  end

  assign Data_dout     = dout_q;
  assign complete_data = cmpl_q;
`ifdef DMEM_OOR_ERR_EN
  assign Data_err      = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Bench for dmem_ctrl, driven by directed vectors. Instance u_dut_a uses
// WAIT_CYCLES=2 and instance u_dut_b uses WAIT_CYCLES=0; both use DEPTH=1024.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// Latency counts falling edges after the request edge until the first one at
// which complete_data is seen high. That is the number of rising edges after
// the request at which complete_data is high.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clock;
  logic        reset;

  logic        a_req, a_rd, a_cmpl, a_err;
  logic [15:0] a_addr, a_din, a_dout;
  logic        b_req, b_rd, b_cmpl, b_err;
  logic [15:0] b_addr, b_din, b_dout;

  int n_chk;
  int n_bad;

  dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
    .clock         (clock),
    .reset         (reset),
    .Data_req      (a_req),
    .Data_rd       (a_rd),
    .Data_addr     (a_addr),
    .Data_din      (a_din),
    .Data_dout     (a_dout),
    .complete_data (a_cmpl)
`ifdef DMEM_OOR_ERR_EN
    ,
    .Data_err      (a_err)
`endif
  );

  dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut_b (
    .clock         (clock),
    .reset         (reset),
    .Data_req      (b_req),
    .Data_rd       (b_rd),
    .Data_addr     (b_addr),
    .Data_din      (b_din),
    .Data_dout     (b_dout),
    .complete_data (b_cmpl)
`ifdef DMEM_OOR_ERR_EN
    ,
    .Data_err      (b_err)
`endif
  );

`ifndef DMEM_OOR_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one access on instance a (sel=0) or b (sel=1). The task starts and
  // ends just after a falling edge. It returns the latency, read data and
  // error flag, and it checks that the pulse lasts exactly one cycle.
  task automatic do_acc(input bit sel, input bit rd, input logic [15:0] addr,
                        input logic [15:0] din, output logic [15:0] dout,
                        output int lat, output logic err);
    if (sel) begin
      b_req = 1'b1; b_rd = rd; b_addr = addr; b_din = din;
    end else begin
      a_req = 1'b1; a_rd = rd; a_addr = addr; a_din = din;
    end
    @(negedge clock);
    a_req = 1'b0;
    b_req = 1'b0;
    lat = 1;
    while (!(sel ? b_cmpl : a_cmpl) && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    dout = sel ? b_dout : a_dout;
    err  = sel ? b_err : a_err;
    @(negedge clock);
    check_eq("pulse_width", {31'd0, (sel ? b_cmpl : a_cmpl)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        e;
    int          lat;
    int          pulses;
    int          bad_idle;
    logic [15:0] rd_val;

    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    a_req = 1'b0; a_rd = 1'b0; a_addr = 16'h0; a_din = 16'h0;
    b_req = 1'b0; b_rd = 1'b0; b_addr = 16'h0; b_din = 16'h0;
    repeat (3) @(negedge clock);
    check_eq("rst_cmpl", {31'd0, a_cmpl}, 32'd0);
    check_eq("rst_dout", {16'd0, a_dout}, 32'd0);
    check_eq("rst_err", {31'd0, a_err}, 32'd0);
    reset = 1'b1;

    // With no requests, both outputs must stay idle for 20 cycles.
    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_cmpl || b_cmpl || a_dout != 16'h0 || b_dout != 16'h0) bad_idle++;
    end
    check_eq("idle_quiet", bad_idle, 0);

    // Instance a (WAIT_CYCLES=2): write BEEF to address 0x10, then read it back.
    do_acc(1'b0, 1'b0, 16'h0010, 16'hBEEF, d, lat, e);
    check_eq("wr_lat_w2", lat, 3);
    check_eq("wr_err_w2", {31'd0, e}, 32'd0);
    check_eq("wr_dout_hold", {16'd0, d}, 32'd0);
    do_acc(1'b0, 1'b1, 16'h0010, 16'h0000, d, lat, e);
    check_eq("rd_lat_w2", lat, 3);
    check_eq("rd_data_w2", {16'd0, d}, 32'h0000BEEF);

    // Instance b (WAIT_CYCLES=0): fill two words, then read both back-to-back.
    do_acc(1'b1, 1'b0, 16'h0001, 16'h1111, d, lat, e);
    check_eq("wr_lat_w0", lat, 1);
    do_acc(1'b1, 1'b0, 16'h0002, 16'h2222, d, lat, e);
    b_req = 1'b1; b_rd = 1'b1; b_addr = 16'h0001;
    @(negedge clock);
    check_eq("b2b_p1", {31'd0, b_cmpl}, 32'd1);
    check_eq("b2b_d1", {16'd0, b_dout}, 32'h00001111);
    b_addr = 16'h0002;
    @(negedge clock);
    check_eq("b2b_gap", {31'd0, b_cmpl}, 32'd0);
    @(negedge clock);
    check_eq("b2b_p2", {31'd0, b_cmpl}, 32'd1);
    check_eq("b2b_d2", {16'd0, b_dout}, 32'h00002222);
    b_req = 1'b0;
    @(negedge clock);
    check_eq("b2b_end", {31'd0, b_cmpl}, 32'd0);
    do_acc(1'b1, 1'b0, 16'h0003, 16'h3333, d, lat, e);
    check_eq("w0_dout_hold", {16'd0, d}, 32'h00002222);

    // A request during WAIT is ignored, and bus changes after sampling have
    // no effect on the transaction in flight.
    do_acc(1'b0, 1'b0, 16'h0005, 16'h1234, d, lat, e);
    a_req = 1'b1; a_rd = 1'b1; a_addr = 16'h0005;
    @(negedge clock);
    a_req = 1'b1; a_rd = 1'b0; a_addr = 16'h0010; a_din = 16'hFFFF;
    @(negedge clock);
    a_req = 1'b0;
    pulses = 0;
    rd_val = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (a_cmpl) begin
        pulses++;
        rd_val = a_dout;
      end
      @(negedge clock);
    end
    check_eq("ignore_pulses", pulses, 1);
    check_eq("ignore_data", {16'd0, rd_val}, 32'h00001234);
    do_acc(1'b0, 1'b1, 16'h0010, 16'h0000, d, lat, e);
    check_eq("ignore_nowr", {16'd0, d}, 32'h0000BEEF);

    // Reset in WAIT aborts a write: there is no pulse and no commit, and
    // Data_dout clears.
    do_acc(1'b0, 1'b0, 16'h0020, 16'h5555, d, lat, e);
    a_req = 1'b1; a_rd = 1'b0; a_addr = 16'h0020; a_din = 16'hAAAA;
    @(negedge clock);
    a_req = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("abort_cmpl", {31'd0, a_cmpl}, 32'd0);
    check_eq("abort_dout", {16'd0, a_dout}, 32'd0);
    check_eq("abort_dout_b", {16'd0, b_dout}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (a_cmpl) pulses++;
    end
    check_eq("abort_nopulse", pulses, 0);
    do_acc(1'b0, 1'b1, 16'h0020, 16'h0000, d, lat, e);
    check_eq("abort_nocommit", {16'd0, d}, 32'h00005555);
    do_acc(1'b1, 1'b1, 16'h0001, 16'h0000, d, lat, e);
    check_eq("mem_kept_b", {16'd0, d}, 32'h00001111);

    // Address 0x403 is beyond DEPTH=1024.
    do_acc(1'b0, 1'b0, 16'h0003, 16'h3333, d, lat, e);
    do_acc(1'b0, 1'b0, 16'h0403, 16'h7777, d, lat, e);
    check_eq("oor_wr_lat", lat, 3);
`ifdef DMEM_OOR_ERR_EN
    check_eq("oor_wr_err", {31'd0, e}, 32'd1);
    @(negedge clock);
    check_eq("oor_err_fall", {31'd0, a_err}, 32'd0);
    do_acc(1'b0, 1'b1, 16'h0403, 16'h0000, d, lat, e);
    check_eq("oor_rd_data", {16'd0, d}, 32'h0000DEAD);
    check_eq("oor_rd_err", {31'd0, e}, 32'd1);
    do_acc(1'b0, 1'b1, 16'h0003, 16'h0000, d, lat, e);
    check_eq("oor_alias_kept", {16'd0, d}, 32'h00003333);
    check_eq("inrange_err", {31'd0, e}, 32'd0);
`else
    check_eq("wrap_wr_err", {31'd0, e}, 32'd0);
    do_acc(1'b0, 1'b1, 16'h0003, 16'h0000, d, lat, e);
    check_eq("wrap_rd_data", {16'd0, d}, 32'h00007777);
    do_acc(1'b0, 1'b1, 16'h0403, 16'h0000, d, lat, e);
    check_eq("wrap_rd_hi", {16'd0, d}, 32'h00007777);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
